output_signature: RTL and testbench

Downstream compactor for the generated combinational test module. It accepts one wide output vector `y` per handshake and folds it, `CHUNK_W` bits per cycle, into a multiple-input signature register (MISR). It publishes the resulting signature and a vector count, so that synthesized and reference netlists can be compared by signature rather than bit-by-bit over 1373-bit outputs.

---
 rtl/signature_pkg.sv | 30 +++
 rtl/output_signature_misr_reg.sv | 36 +++
 rtl/output_signature.sv | 139 +++++++++++++
 tb/tb_output_signature.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signature_pkg.sv
// Shared MISR definitions: default polynomial/seed, FSM state type and step helpers.
// Used by output_signature and other signature checkers.
package signature_pkg;

  localparam logic [31:0] DEF_POLY   = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED   = 32'hFFFFFFFF;
  localparam int          MISR_MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    FOLD = 1'b1
  } sig_state_t;

  function automatic int nchunk(input int in_w, input int chunk_w);
    return (in_w + chunk_w - 1) / chunk_w;
  endfunction

  // One shift/feedback/xor step on the low w bits; callers truncate to w.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] chunk,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    w
  );
    logic fb;
    fb = ((sig >> (w - 1)) & MISR_MAX_W'(1)) != '0;
    return (sig << 1) ^ (fb ? poly : '0) ^ chunk;
  endfunction

endpackage

// File: rtl/output_signature_misr_reg.sv
// W-bit multiple-input signature register with load-seed and step controls.
// Load-seed wins over step; reset also loads the seed.
module misr_reg
  import signature_pkg::*;
#(
  parameter int           W    = 32,
  parameter logic [W-1:0] POLY = W'(DEF_POLY),
  parameter logic [W-1:0] SEED = W'(DEF_SEED)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load_seed,
  input  logic         i_step,
  input  logic [W-1:0] i_chunk,
  output logic [W-1:0] o_sig
);

  logic [W-1:0] r_sig;
  logic [W-1:0] w_next;

  assign w_next = W'(misr_step(MISR_MAX_W'(r_sig), MISR_MAX_W'(i_chunk),
                               MISR_MAX_W'(POLY), W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= SEED;
    end else if (i_load_seed) begin
      r_sig <= SEED;
    end else if (i_step) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/output_signature.sv
// Folds one IN_W-bit vector per handshake into a CHUNK_W-bit MISR, LSB chunk first.
// Optional expected-signature compare is built when OUTPUT_SIGNATURE_COMPARE_EN is defined.
//
// state | meaning
// IDLE  | ready for a vector; signature stable
// FOLD  | folding one chunk of the held vector per cycle
module output_signature
  import signature_pkg::*;
#(
  parameter int                 IN_W    = 1373,
  parameter int                 CHUNK_W = 32,
  parameter logic [CHUNK_W-1:0] POLY    = CHUNK_W'(DEF_POLY),
  parameter logic [CHUNK_W-1:0] SEED    = CHUNK_W'(DEF_SEED)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic [CHUNK_W-1:0] sig_out,
  output logic               sig_valid,
  output logic [15:0]        count_out,
  output logic               busy
`ifdef OUTPUT_SIGNATURE_COMPARE_EN
  ,
  input  logic [CHUNK_W-1:0] exp_sig,
  output logic               mismatch
`endif
);

  localparam int NCHUNK = nchunk(IN_W, CHUNK_W);
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  sig_state_t         r_state;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_sig_valid;
  logic [IDX_W-1:0]   r_idx;
  logic [PAD_W-1:0]   r_hold;
  logic [15:0]        r_count;
  logic [PAD_W-1:0]   w_in_pad;
  logic [CHUNK_W-1:0] w_chunk;
  logic               w_step;

  generate
    if (PAD_W > IN_W) begin : g_pad
      assign w_in_pad = {{(PAD_W - IN_W){1'b0}}, in_data};
    end else begin : g_nopad
      assign w_in_pad = in_data;
    end
  endgenerate

  // The hold register shifts down one chunk per fold, so the current chunk is always at the bottom.
  assign w_chunk = r_hold[CHUNK_W-1:0];
  assign w_step  = (r_state == FOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
      r_idx       <= '0;
      r_hold      <= '0;
      r_count     <= '0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
      r_idx       <= '0;
      r_count     <= '0;
    end else begin
      r_sig_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state    <= FOLD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_idx      <= '0;
            r_hold     <= w_in_pad;
          end
        end
        FOLD: begin
          r_hold <= r_hold >> CHUNK_W;
          if (r_idx == LAST_IDX) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_sig_valid <= 1'b1;
            r_count     <= r_count + 16'd1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  misr_reg #(
    .W    (CHUNK_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk         (clk),
    .rst         (rst),
    .i_load_seed (clear),
    .i_step      (w_step),
    .i_chunk     (w_chunk),
    .o_sig       (sig_out)
  );

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign sig_valid = r_sig_valid;
  assign count_out = r_count;

`ifdef OUTPUT_SIGNATURE_COMPARE_EN
  logic r_mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
    end else if (clear) begin
      r_mismatch <= 1'b0;
    end else if (r_sig_valid && (sig_out != exp_sig)) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_output_signature.sv
// Self-checking bench for output_signature: random vectors against a chunk-list MISR model,
// plus small-width instances for the hand-computed signature cases.
module tb_output_signature;

  localparam int          IN_W = 1373;
  localparam int          NCK  = 43;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clear, in_valid, in_ready, sig_valid, busy;
  logic [IN_W-1:0] in_data;
  logic [31:0]     sig_out;
  logic [15:0]     count_out;

  logic        s64_clear, s64_valid, s64_ready, s64_sv, s64_busy;
  logic [63:0] s64_data;
  logic [31:0] s64_sig;
  logic [15:0] s64_cnt;

  logic        s32_clear, s32_valid, s32_ready, s32_sv, s32_busy;
  logic [31:0] s32_data;
  logic [31:0] s32_sig;
  logic [15:0] s32_cnt;

`ifdef OUTPUT_SIGNATURE_COMPARE_EN
  logic [31:0] exp_sig;
  logic        mismatch, s64_mm, s32_mm;
`endif

  output_signature u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sig_out(sig_out), .sig_valid(sig_valid), .count_out(count_out),
    .busy(busy)
`ifdef OUTPUT_SIGNATURE_COMPARE_EN
    , .exp_sig(exp_sig), .mismatch(mismatch)
`endif
  );

  output_signature #(.IN_W(64), .SEED(32'h0)) u_s64 (
    .clk(clk), .rst(rst), .clear(s64_clear), .in_valid(s64_valid), .in_ready(s64_ready),
    .in_data(s64_data), .sig_out(s64_sig), .sig_valid(s64_sv), .count_out(s64_cnt),
    .busy(s64_busy)
`ifdef OUTPUT_SIGNATURE_COMPARE_EN
    , .exp_sig(32'h0), .mismatch(s64_mm)
`endif
  );

  output_signature #(.IN_W(32), .SEED(32'h80000000)) u_s32 (
    .clk(clk), .rst(rst), .clear(s32_clear), .in_valid(s32_valid), .in_ready(s32_ready),
    .in_data(s32_data), .sig_out(s32_sig), .sig_valid(s32_sv), .count_out(s32_cnt),
    .busy(s32_busy)
`ifdef OUTPUT_SIGNATURE_COMPARE_EN
    , .exp_sig(32'h0), .mismatch(s32_mm)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: split the vector into w-bit-wide 32-bit chunks, fold each with the MISR rule.
  function automatic logic [31:0] fold(input logic [31:0] s, input logic [IN_W-1:0] v, input int w);
    int          n;
    logic [31:0] c;
    logic [31:0] q[$];
    n = (w + 31) / 32;
    for (int i = 0; i < n; i++) begin
      c = 32'(v >> (32 * i));
      q.push_back(c);
    end
    while (q.size() > 0) begin
      c = q.pop_front();
      s = (s << 1) ^ ((s >= 32'h80000000) ? POLY : 32'h0) ^ c;
    end
    return s;
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] r;
    r = '0;
    for (int j = 0; j < 44; j++) r = {r[IN_W-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs the main instance from just after an acceptance edge to its sig_valid cycle.
  task automatic wait_valid(output int lat, output int low);
    lat = 0;
    low = 1;
    while (!sig_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) low++;
    end
  endtask

  task automatic s64_send(input logic [63:0] v, output int lat);
    s64_valid = 1'b1;
    s64_data  = v;
    @(posedge clk); #1;
    s64_valid = 1'b0;
    s64_data  = 64'($urandom());
    lat = 0;
    while (!s64_sv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] v, prev_v, v2;
    logic [31:0]     model_sig, tmp_sig;
    int              model_cnt, lat, low, t_prev;
    logic [63:0]     sv;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    s64_clear = 1'b0; s64_valid = 1'b0; s64_data = '0;
    s32_clear = 1'b0; s32_valid = 1'b0; s32_data = '0;
`ifdef OUTPUT_SIGNATURE_COMPARE_EN
    exp_sig = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sig", sig_out, SEED);
    check("rst_sig_valid", sig_valid, 0);
    check("rst_count", count_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    model_sig = SEED;
    model_cnt = 0;

    // Back-to-back stream with in_valid held high; last vector differs only in bit IN_W-1.
    in_valid = 1'b1;
    prev_v   = '0;
    t_prev   = 0;
    for (int k = 0; k < 4; k++) begin
      v = rand_vec();
      if (k == 3) begin
        v = prev_v;
        v[IN_W-1] = ~v[IN_W-1];
      end
      in_data = v;
      @(posedge clk); #1;
      if (k > 0) check("pulse_one_cycle", sig_valid, 0);
      check("accept_ready_low", in_ready, 0);
      check("accept_busy", busy, 1);
      in_data = rand_vec();
      wait_valid(lat, low);
      model_sig = fold(model_sig, v, IN_W);
      model_cnt++;
      check("fold_latency", lat, NCK);
      check("ready_low_cycles", low, NCK);
      check("sig_valid_pulse", sig_valid, 1);
      check("ready_with_valid", in_ready, 1);
      check("stream_sig", sig_out, model_sig);
      check("stream_count", count_out, model_cnt);
      if (k > 0) check("valid_period", cyc - t_prev, NCK + 1);
      t_prev = cyc;
      prev_v = v;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_sig_valid", sig_valid, 0);
    check("idle_sig_stable", sig_out, model_sig);
    check("idle_count", count_out, 4);

    // Clear at chunk 20 with a new vector offered during the clear cycle.
    in_valid = 1'b1;
    in_data  = rand_vec();
    @(posedge clk); #1;
    v2 = rand_vec();
    in_data = v2;
    repeat (20) @(posedge clk);
    #1;
    check("pre_clear_busy", busy, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_sig_valid", sig_valid, 0);
    check("clear_sig", sig_out, SEED);
    check("clear_count", count_out, 0);
    check("clear_not_accepted", in_ready, 1);
    check("clear_busy", busy, 0);
    @(posedge clk); #1;
    check("accept_after_clear", in_ready, 0);
    in_valid = 1'b0;
    in_data  = rand_vec();
    wait_valid(lat, low);
    model_sig = fold(SEED, v2, IN_W);
    check("post_clear_latency", lat, NCK);
    check("post_clear_sig", sig_out, model_sig);
    check("post_clear_count", count_out, 1);

    // Asynchronous reset in the middle of a fold.
    in_valid = 1'b1;
    in_data  = rand_vec();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_sig", sig_out, SEED);
    check("arst_count", count_out, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_sig_valid", sig_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    v = rand_vec();
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    wait_valid(lat, low);
    check("post_rst_sig", sig_out, fold(SEED, v, IN_W));
    check("post_rst_count", count_out, 1);

    // 64-bit instance, seed 0: chunk order sensitivity.
    s64_send({32'h0, 32'h1}, lat);
    check("s64_latency", lat, 2);
    check("s64_sig_lo", s64_sig, 32'h00000002);
    check("s64_count", s64_cnt, 1);
    @(posedge clk); #1;
    check("s64_pulse_one_cycle", s64_sv, 0);
    s64_clear = 1'b1;
    @(posedge clk); #1;
    s64_clear = 1'b0;
    check("s64_clear_sig", s64_sig, 32'h0);
    s64_send({32'h1, 32'h0}, lat);
    check("s64_sig_hi", s64_sig, 32'h00000001);
    tmp_sig = 32'h00000001;
    for (int r = 0; r < 3; r++) begin
      sv = {32'($urandom()), 32'($urandom())};
      s64_send(sv, lat);
      tmp_sig = fold(tmp_sig, IN_W'(sv), 64);
      check("s64_rand_sig", s64_sig, tmp_sig);
    end
    check("s64_rand_count", s64_cnt, 4);

    // 32-bit instance, seed with MSB set: feedback path alone.
    s32_valid = 1'b1;
    s32_data  = 32'h0;
    @(posedge clk); #1;
    s32_valid = 1'b0;
    s32_data  = 32'hDEADBEEF;
    lat = 0;
    while (!s32_sv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("s32_latency", lat, 1);
    check("s32_feedback_sig", s32_sig, 32'h04C11DB7);

`ifdef OUTPUT_SIGNATURE_COMPARE_EN
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("cmp_clear", mismatch, 0);
    v = rand_vec();
    model_sig = fold(SEED, v, IN_W);
    exp_sig = ~model_sig;
    in_valid = 1'b1; in_data = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat, low);
    @(posedge clk); #1;
    check("cmp_mismatch_set", mismatch, 1);
    v = rand_vec();
    model_sig = fold(model_sig, v, IN_W);
    exp_sig = model_sig;
    in_valid = 1'b1; in_data = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat, low);
    @(posedge clk); #1;
    check("cmp_mismatch_sticky", mismatch, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("cmp_mismatch_cleared", mismatch, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
